// File: rtl/neuron_pkg.sv
// Shared types for the neuron datapath: product/result widths, the Q1.7
// result type and the accumulator state encoding.
// Optional feature macro used by the accumulator: NEURON_RELU_EN.
package neuron_pkg;

    localparam int IN_W  = 9;   // signed Q2.7 product
    localparam int OUT_W = 8;   // signed Q1.7 bias/result

    typedef logic signed [IN_W-1:0]  prod_t;
    typedef logic signed [OUT_W-1:0] q17_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/neuron_accumulator_if.sv
// Product-in / result-out handshake bundle of the neuron accumulator.
// master: producer of products and consumer of results; slave: accumulator.
interface neuron_accumulator_if
    import neuron_pkg::*;
#(
    parameter int P_W = neuron_pkg::IN_W,
    parameter int Q_W = neuron_pkg::OUT_W
);
    logic                  prod_valid;
    logic                  prod_ready;
    logic signed [P_W-1:0] prod;
    logic signed [Q_W-1:0] bias;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [Q_W-1:0] out_data;

    modport master (
        output prod_valid, prod, bias, out_ready,
        input  prod_ready, out_valid, out_data
    );

    modport slave (
        input  prod_valid, prod, bias, out_ready,
        output prod_ready, out_valid, out_data
    );
endinterface

// File: rtl/neuron_accumulator_sat.sv
// q17_saturate: combinational signed clamp from an ACC_W-bit accumulator to
// an OUT_W-bit result, no rounding. Requires ACC_W >= OUT_W.
module q17_saturate #(
    parameter int ACC_W = 12,
    parameter int OUT_W = 8
) (
    input  logic signed [ACC_W-1:0] din,
    output logic signed [OUT_W-1:0] dout
);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    function automatic logic signed [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] c;
        if (v > SAT_MAX)
            c = SAT_MAX;
        else if (v < SAT_MIN)
            c = SAT_MIN;
        else
            c = v;
        return c[OUT_W-1:0];
    endfunction

    // Clamp the accumulator into the representable result range.
    always_comb begin
        dout = sat(din);
    end
endmodule

// File: rtl/neuron_accumulator.sv
// neuron_accumulator: sums N_INPUTS signed Q2.7 products plus a signed Q1.7
// bias, saturates to Q1.7 and holds the result until it is taken.
// Macro NEURON_RELU_EN: when defined, negative results are forced to 0.
module neuron_accumulator
    import neuron_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int IN_W     = neuron_pkg::IN_W,
    parameter int OUT_W    = neuron_pkg::OUT_W,
    parameter int ACC_W    = IN_W + $clog2(N_INPUTS) + 1
) (
    input logic                 clk,
    input logic                 rst,
    neuron_accumulator_if.slave bus
);
    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS + 1) : 1;

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic signed [OUT_W-1:0] out_q, sat_out, res;
    logic                    accept;

    // Handshake flags are decoded from the registered state only, so
    // out_ready never reaches prod_ready combinationally.
    assign bus.prod_ready = (state != DONE);
    assign bus.out_valid  = (state == DONE);
    assign bus.out_data   = out_q;
    assign accept         = bus.prod_valid && (state != DONE);

    q17_saturate #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat (
        .din  (acc_nxt),
        .dout (sat_out)
    );

    // Optional rectification of the saturated sum.
    always_comb begin
`ifdef NEURON_RELU_EN
        res = sat_out[OUT_W-1] ? '0 : sat_out;
`else
        res = sat_out;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and accumulator update; bias only enters on the first product.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    acc_nxt   = ACC_W'(bus.bias) + ACC_W'(bus.prod);
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = (N_INPUTS == 1) ? DONE : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    acc_nxt = acc + ACC_W'(bus.prod);
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt_nxt == CNT_W'(N_INPUTS))
                        state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers; the result is captured on the final accept and held through DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            out_q <= '0;
        end else begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            if (state != DONE && state_nxt == DONE)
                out_q <= res;
        end
    end
endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator: N_INPUTS=4 instance plus an
// N_INPUTS=1 instance. Honours NEURON_RELU_EN for expected values.
module tb_neuron_accumulator;
    import neuron_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    neuron_accumulator_if bus4 ();
    neuron_accumulator_if bus1 ();

    neuron_accumulator #(.N_INPUTS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    neuron_accumulator #(.N_INPUTS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    // Present one product to the N=4 instance and return just after it is accepted.
    task automatic put4(input int p, input int b);
        int n = 0;
        bus4.prod_valid = 1'b1;
        bus4.prod       = 9'(p);
        bus4.bias       = 8'(b);
        while (!bus4.prod_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL put4_timeout: prod_ready=%0b required 1", bus4.prod_ready);
        end
        @(posedge clk); #1;
        bus4.prod_valid = 1'b0;
    endtask

    task automatic put1(input int p, input int b);
        int n = 0;
        bus1.prod_valid = 1'b1;
        bus1.prod       = 9'(p);
        bus1.bias       = 8'(b);
        while (!bus1.prod_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL put1_timeout: prod_ready=%0b required 1", bus1.prod_ready);
        end
        @(posedge clk); #1;
        bus1.prod_valid = 1'b0;
    endtask

    task automatic idle(input int c);
        repeat (c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);
        checks++;
        if (bus4.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %0b want 0", bus4.out_valid);
        end
        checks++;
        if (bus4.out_data !== 8'sd0) begin
            errors++; $display("FAIL reset_out_data: got %0d want 0", bus4.out_data);
        end
        checks++;
        if (bus4.prod_ready !== 1'b1) begin
            errors++; $display("FAIL reset_prod_ready: got %0b want 1", bus4.prod_ready);
        end
        checks++;
        if (bus1.prod_ready !== 1'b1 || bus1.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_n1: ready=%0b valid=%0b want 1 0", bus1.prod_ready, bus1.out_valid);
        end
    endtask

    // Take the pending N=4 result and check it; returns after the handshake edge.
    task automatic take4(input string name, input int want);
        int n = 0;
        while (!bus4.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bus4.out_valid !== 1'b1 || bus4.out_data !== 8'(want)) begin
            errors++;
            $display("FAIL %s: out_valid=%0b out_data=%0d want valid 1 data %0d",
                     name, bus4.out_valid, bus4.out_data, want);
        end
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.out_ready = 1'b0;
        checks++;
        if (bus4.out_valid !== 1'b0) begin
            errors++; $display("FAIL %s_drop: out_valid=%0b want 0", name, bus4.out_valid);
        end
    endtask

    task automatic test_pos_saturation();
        put4(64, 0); put4(64, 0); put4(64, 0);
        checks++;
        if (bus4.out_valid !== 1'b0) begin
            errors++; $display("FAIL sat_early_valid: got %0b want 0", bus4.out_valid);
        end
        put4(64, 0);
        checks++;
        if (bus4.out_valid !== 1'b1 || bus4.prod_ready !== 1'b0) begin
            errors++;
            $display("FAIL sat_latency: valid=%0b ready=%0b want 1 0", bus4.out_valid, bus4.prod_ready);
        end
        take4("pos_sat", 127);
    endtask

    task automatic test_mixed_and_gaps();
        put4(16, 10); put4(16, 77); put4(-8, -5); put4(4, 99);
        take4("mixed", 38);
        put4(16, 10); idle(3); put4(16, 1); idle(3); put4(-8, 2); idle(3); put4(4, 3);
        take4("gapped", 38);
    endtask

    task automatic test_neg_saturation();
        int want;
`ifdef NEURON_RELU_EN
        want = 0;
`else
        want = -128;
`endif
        put4(-200, -128); put4(-200, 0); put4(-200, 0); put4(-200, 0);
        take4("neg_sat", want);
    endtask

    task automatic test_backpressure();
        put4(1, 0); put4(1, 0); put4(1, 0); put4(1, 0);
        bus4.prod_valid = 1'b1;
        bus4.prod       = 9'sd99;
        bus4.bias       = 8'sd50;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus4.out_valid !== 1'b1 || bus4.out_data !== 8'sd4 || bus4.prod_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: valid=%0b data=%0d ready=%0b want 1 4 0",
                         i, bus4.out_valid, bus4.out_data, bus4.prod_ready);
            end
        end
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.out_ready  = 1'b0;
        bus4.prod_valid = 1'b0;
        checks++;
        if (bus4.out_valid !== 1'b0 || bus4.prod_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: valid=%0b ready=%0b want 0 1", bus4.out_valid, bus4.prod_ready);
        end
        put4(1, 5); put4(2, 0); put4(3, 0); put4(4, 0);
        take4("fresh_bias", 15);
    endtask

    task automatic test_reset_mid();
        put4(7, 0); put4(7, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (bus4.out_valid !== 1'b0 || bus4.prod_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: valid=%0b ready=%0b want 0 1", bus4.out_valid, bus4.prod_ready);
        end
        put4(1, 0); put4(2, 0); put4(3, 0); put4(4, 0);
        checks++;
        if (bus4.out_valid !== 1'b1) begin
            errors++; $display("FAIL rst_pending: valid=%0b want 1", bus4.out_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (bus4.out_valid !== 1'b0 || bus4.out_data !== 8'sd0) begin
            errors++;
            $display("FAIL rst_done: valid=%0b data=%0d want 0 0", bus4.out_valid, bus4.out_data);
        end
        put4(1, 0); put4(2, 0); put4(3, 0); put4(4, 0);
        take4("after_rst", 10);
    endtask

    task automatic test_negative_result();
        int want;
`ifdef NEURON_RELU_EN
        want = 0;
`else
        want = -20;
`endif
        put4(5, -30); put4(5, 0); put4(0, 0); put4(0, 0);
        take4("neg_result", want);
    endtask

    task automatic test_single_input();
        int n;
        put1(4, 3);
        checks++;
        if (bus1.out_valid !== 1'b1 || bus1.out_data !== 8'sd7) begin
            errors++;
            $display("FAIL n1_sum: valid=%0b data=%0d want 1 7", bus1.out_valid, bus1.out_data);
        end
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
        put1(100, 100);
        n = 0;
        checks++;
        if (bus1.out_valid !== 1'b1 || bus1.out_data !== 8'sd127) begin
            errors++;
            $display("FAIL n1_sat: valid=%0b data=%0d want 1 127", bus1.out_valid, bus1.out_data);
        end
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
        checks++;
        if (bus1.out_valid !== 1'b0) begin
            errors++; $display("FAIL n1_drop: valid=%0b want 0", bus1.out_valid);
        end
    endtask

    initial begin
        bus4.prod_valid = 1'b0; bus4.prod = '0; bus4.bias = '0; bus4.out_ready = 1'b0;
        bus1.prod_valid = 1'b0; bus1.prod = '0; bus1.bias = '0; bus1.out_ready = 1'b0;
        test_reset();
        test_pos_saturation();
        test_mixed_and_gaps();
        test_neg_saturation();
        test_backpressure();
        test_reset_mid();
        test_negative_result();
        test_single_input();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
